// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Requester ids, default widths and the arbiter FSM encoding.
package mem_arb_pkg;

  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_TIMEOUT = 1024;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_STORE = 2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: first set request at or above
// rr_ptr, wrapping at NUM_REQ. Purely combinational.
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  // Walk the requesters starting at the pointer; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        any = 1'b1;
        grant[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
        idx = IW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing the memory bus among fetch/load/store.
// Optional response watchdog: define MEMORY_ARBITER_TIMEOUT_EN.
module memory_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_error,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_data,
  output logic                      busy,
  output logic                      spurious_resp
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state_q, state_d;

  logic [IW-1:0]      rr_ptr_q;
  logic [IW-1:0]      gnt_idx_q;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic               pick_any;

  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;

  logic [NUM_REQ-1:0] resp_valid_q;
  logic [DATA_W-1:0]  resp_data_q;
  logic               spurious_q;

  logic accept;
  logic done;
  logic timeout;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req    (req_valid),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_grant),
    .idx    (pick_idx),
    .any    (pick_any)
  );

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          resp_error_q;

  // The last waiting cycle is the one where the count would reach
  // TIMEOUT_CYCLES; a real response in that cycle takes priority.
  assign timeout = (state_q == WAIT_RESP)
                && (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1))
                && !mem_resp_valid;

  // Count cycles spent in WAIT_RESP; zero everywhere else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q   <= '0;
      resp_error_q <= 1'b0;
    end else begin
      resp_error_q <= timeout;
      if (state_q != WAIT_RESP)
        wait_cnt_q <= '0;
      else
        wait_cnt_q <= wait_cnt_q + CW'(1);
    end
  end

  assign resp_error = resp_error_q;
`else
  assign timeout    = 1'b0;
  assign resp_error = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next state, grant and memory request strobe.
  always_comb begin
    state_d       = state_q;
    req_ready     = '0;
    mem_req_valid = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          accept    = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (mem_resp_valid || timeout) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, response routing, pointer and spurious flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= IW'(REQ_FETCH);
      gnt_idx_q    <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      spurious_q   <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      if (accept) begin
        gnt_idx_q <= pick_idx;
        addr_q    <= req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        write_q   <= req_write[pick_idx];
        wdata_q   <= req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
      end
      if (done) begin
        resp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
        resp_data_q  <= (write_q || timeout) ? '0 : mem_resp_data;
        rr_ptr_q     <= (gnt_idx_q == IW'(NUM_REQ - 1))
                      ? '0 : gnt_idx_q + IW'(1);
      end
      if (mem_resp_valid && (state_q != WAIT_RESP))
        spurious_q <= 1'b1;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign mem_addr      = addr_q;
  assign mem_write     = write_q;
  assign mem_wdata     = wdata_q;
  assign busy          = (state_q != IDLE);
  assign spurious_resp = spurious_q;

endmodule
